// File: rtl/piano_note_gen.sv
// Monophonic square-wave note generator for the 8-key piano.
// Last-pressed key wins; releasing it falls back to the highest still-held key.
module piano_note_gen #(
    parameter int NKEYS = 8,
    parameter int CW    = 18,
    parameter int SHIFT = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [NKEYS-1:0] KEYS,
    output logic             SPEAKER,
    output logic [2:0]       NOTE_IDX,
    output logic             NOTE_VALID
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    counter;
    logic [NKEYS-1:0] keys_q;
    logic [NKEYS-1:0] rise;
    logic [2:0]       next_idx;
    logic             load;
    logic             go_idle;

    // Reload value is H-1, where H is the scaled half period clamped to 2.
    function automatic logic [CW-1:0] reload_of(input logic [2:0] idx);
        int unsigned e;
        case (idx)
            3'd0:    e = 191113;
            3'd1:    e = 170265;
            3'd2:    e = 151685;
            3'd3:    e = 143173;
            3'd4:    e = 127551;
            3'd5:    e = 113636;
            3'd6:    e = 101239;
            default: e = 95557;
        endcase
        e = e >> SHIFT;
        if (e < 2)
            e = 2;
        return CW'(e - 1);
    endfunction

    function automatic logic [2:0] top_bit(input logic [NKEYS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NKEYS; i++)
            if (v[i])
                r = 3'(i);
        return r;
    endfunction

    assign rise       = KEYS & ~keys_q;
    assign NOTE_VALID = state;

    always_comb begin
        load     = 1'b0;
        go_idle  = 1'b0;
        next_idx = NOTE_IDX;
        if (rise != '0) begin
            load     = 1'b1;
            next_idx = top_bit(rise);
        end else if (state == PLAY && !KEYS[NOTE_IDX]) begin
            if (KEYS != '0) begin
                load     = 1'b1;
                next_idx = top_bit(KEYS);
            end else begin
                go_idle = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            counter  <= '0;
            keys_q   <= '0;
            SPEAKER  <= 1'b0;
            NOTE_IDX <= '0;
        end else begin
            keys_q   <= KEYS;
            NOTE_IDX <= next_idx;
            // A (re)load keeps the speaker level; only the phase restarts.
            if (load) begin
                state   <= PLAY;
                counter <= reload_of(next_idx);
            end else if (go_idle || state == IDLE) begin
                state   <= IDLE;
                counter <= '0;
                SPEAKER <= 1'b0;
            end else if (counter == '0) begin
                SPEAKER <= ~SPEAKER;
                counter <= reload_of(NOTE_IDX);
            end else begin
                counter <= counter - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piano_note_gen.sv
// Bench for piano_note_gen: vector table, directed timing sequences and
// randomized key activity against an arithmetic reference model.
module tb_piano_note_gen;

    logic       CLK;
    logic       RESET;
    logic [7:0] KEYS;
    logic       SPEAKER;
    logic [2:0] NOTE_IDX;
    logic       NOTE_VALID;

    int checks;
    int failures;

    piano_note_gen #(.NKEYS(8), .CW(18), .SHIFT(10)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .KEYS(KEYS),
        .SPEAKER(SPEAKER),
        .NOTE_IDX(NOTE_IDX),
        .NOTE_VALID(NOTE_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int TBL[8] = '{191113, 170265, 151685, 143173,
                              127551, 113636, 101239, 95557};

    function automatic int h_of(input int i);
        int h;
        h = TBL[i] >> 10;
        return (h < 2) ? 2 : h;
    endfunction

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i])
                return i;
        return 0;
    endfunction

    // Reference model: speaker level is derived from elapsed time since
    // the last note load, not from a down-counter.
    int         cyc;
    int         t_load;
    logic       spk0;
    logic [7:0] m_kq;
    int         m_idx;
    logic       m_valid;
    logic       m_spk;

    task automatic model(input logic r, input logic [7:0] k);
        logic [7:0] rs;
        cyc++;
        if (!r) begin
            m_spk = 0; m_idx = 0; m_valid = 0; m_kq = 0;
        end else begin
            rs   = k & ~m_kq;
            m_kq = k;
            if (rs != 0) begin
                m_idx = highest(rs); m_valid = 1;
                t_load = cyc; spk0 = m_spk;
            end else if (m_valid && !k[m_idx]) begin
                if (k != 0) begin
                    m_idx = highest(k); t_load = cyc; spk0 = m_spk;
                end else begin
                    m_valid = 0; m_spk = 0;
                end
            end
            if (m_valid)
                m_spk = spk0 ^ (((cyc - t_load) / h_of(m_idx)) % 2 == 1);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    logic [7:0] cur_k;

    task automatic step(input logic r, input logic [7:0] k);
        @(negedge CLK);
        RESET = r; KEYS = k; cur_k = k;
        @(posedge CLK);
        model(r, k);
        #1;
        chk("model {spk,idx,valid}",
            {SPEAKER, NOTE_IDX, NOTE_VALID},
            {m_spk, 3'(m_idx), m_valid});
    endtask

    task automatic cycles_to_toggle(input int lim, output int n);
        logic old;
        old = SPEAKER;
        n = 0;
        while (SPEAKER == old && n < lim) begin
            step(1'b1, cur_k);
            n++;
        end
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] keys;
        logic [2:0] idx;
        logic       valid;
        logic       spk;
    } vec_t;

    vec_t vecs[$];
    int   n;

    initial begin
        checks = 0; failures = 0; cyc = 0; t_load = 0; spk0 = 0;
        m_kq = 0; m_idx = 0; m_valid = 0; m_spk = 0;
        RESET = 1'b0; KEYS = 8'h00; cur_k = 8'h00;

        vecs = '{
            '{1'b0, 8'hFF, 3'd0, 1'b0, 1'b0},
            '{1'b0, 8'hFF, 3'd0, 1'b0, 1'b0},
            '{1'b0, 8'hFF, 3'd0, 1'b0, 1'b0},
            '{1'b1, 8'hFF, 3'd7, 1'b1, 1'b0},
            '{1'b1, 8'h00, 3'd7, 1'b0, 1'b0},
            '{1'b1, 8'h81, 3'd7, 1'b1, 1'b0},
            '{1'b1, 8'h05, 3'd2, 1'b1, 1'b0},
            '{1'b1, 8'h04, 3'd2, 1'b1, 1'b0},
            '{1'b1, 8'h00, 3'd2, 1'b0, 1'b0},
            '{1'b1, 8'h20, 3'd5, 1'b1, 1'b0},
            '{1'b1, 8'h00, 3'd5, 1'b0, 1'b0},
            '{1'b1, 8'h01, 3'd0, 1'b1, 1'b0},
            '{1'b1, 8'h21, 3'd5, 1'b1, 1'b0},
            '{1'b1, 8'h01, 3'd0, 1'b1, 1'b0},
            '{1'b1, 8'h00, 3'd0, 1'b0, 1'b0}
        };
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].keys);
            chk($sformatf("vec%0d idx", i), NOTE_IDX, vecs[i].idx);
            chk($sformatf("vec%0d valid", i), NOTE_VALID, vecs[i].valid);
            chk($sformatf("vec%0d spk", i), SPEAKER, vecs[i].spk);
        end

        // Single C4: first toggle H after NOTE_VALID, then H high, H low
        step(1'b0, 8'h00);
        step(1'b1, 8'h01);
        chk("c4 valid", NOTE_VALID, 1);
        chk("c4 idx", NOTE_IDX, 0);
        cycles_to_toggle(1000, n);
        chk("c4 first rise", n, 186);
        chk("c4 level", SPEAKER, 1);
        cycles_to_toggle(1000, n);
        chk("c4 high time", n, 186);
        cycles_to_toggle(1000, n);
        chk("c4 low time", n, 186);

        // Last pressed wins, then fall back without an idle cycle
        step(1'b1, 8'h21);
        chk("a4 idx", NOTE_IDX, 5);
        cycles_to_toggle(1000, n);
        chk("a4 half", n, 110);
        step(1'b1, 8'h01);
        chk("fallback idx", NOTE_IDX, 0);
        chk("fallback valid", NOTE_VALID, 1);
        cycles_to_toggle(1000, n);
        chk("fallback half", n, 186);

        // Re-press of the sounding key restarts its phase
        step(1'b1, 8'h00);
        step(1'b1, 8'h80);
        repeat (50) step(1'b1, 8'h80);
        step(1'b1, 8'h00);
        step(1'b1, 8'h80);
        cycles_to_toggle(1000, n);
        chk("c5 repress half", n, 93);

        // Reset mid-tone while SPEAKER is high
        step(1'b1, 8'h00);
        step(1'b1, 8'h01);
        cycles_to_toggle(1000, n);
        chk("pre-reset level", SPEAKER, 1);
        step(1'b0, 8'h01);
        chk("reset spk", SPEAKER, 0);
        chk("reset valid", NOTE_VALID, 0);
        step(1'b1, 8'h01);
        chk("restart valid", NOTE_VALID, 1);
        cycles_to_toggle(1000, n);
        chk("restart half", n, 186);

        // Randomized key activity against the model
        for (int c = 0; c < 6000; c++) begin
            logic [7:0] k;
            logic       r;
            k = cur_k;
            r = ($urandom_range(0, 799) != 0);
            case ($urandom_range(0, 199))
                0, 1:    k = 8'($urandom);
                2, 3, 4: k = cur_k ^ (8'h01 << $urandom_range(0, 7));
                5:       k = 8'h00;
                default: k = cur_k;
            endcase
            step(r, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
